// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage register scoreboard and stall sequencer.
// Tracks in-flight writers per register, counts down until each result is
// bypassable, and stalls ID on unbypassable operands or a busy long unit.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                id_valid_i,
    input  logic [4:0]          id_rs1_i,
    input  logic [4:0]          id_rs2_i,
    input  logic                id_use_rs1_i,
    input  logic                id_use_rs2_i,
    input  logic                id_long_i,
    input  logic                issue_i,
    input  logic                issue_wr_i,
    input  logic [4:0]          issue_rd_i,
    input  logic [1:0]          issue_kind_i,
    input  logic                long_done_i,
    input  logic                wb_valid_i,
    input  logic                wb_wr_i,
    input  logic [4:0]          wb_rd_i,
    input  logic                flush_i,
    output logic                stall_id_o,
    output logic                long_busy_o,
    output logic [NUM_REGS-1:0] pending_o
);

    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_LONG = 2'd2;
    localparam logic [1:0] LOAD_RDY  = 2'(LOAD_LAT);

    typedef enum logic {LIDLE = 1'b0, LBUSY = 1'b1} lstate_e;

    lstate_e                  r_state, w_state_nxt;
    logic [NUM_REGS-1:0][1:0] r_cnt, r_rdy, w_cnt_nxt, w_rdy_nxt;
    logic [NUM_REGS-1:0]      r_lng, w_lng_nxt, w_iss_hit, w_wb_hit;
    logic                     w_busy, w_long_clr, w_iss_long;
    logic                     w_rs1_blk, w_rs2_blk, w_struct;

    assign w_busy     = (r_state == LBUSY);
    assign w_long_clr = w_busy & long_done_i;
    assign w_iss_long = issue_i & (issue_kind_i == KIND_LONG);

    // Long-unit next state; a new long op landing with long_done keeps it busy
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LIDLE:   if (w_iss_long) w_state_nxt = LBUSY;
            LBUSY:   if (long_done_i && !w_iss_long) w_state_nxt = LIDLE;
            default: w_state_nxt = LIDLE;
        endcase
    end

    // Long-unit state register; flush abandons the long op like reset does
    always_ff @(posedge clk_i) begin
        if (!rsn_i || flush_i) r_state <= LIDLE;
        else                   r_state <= w_state_nxt;
    end

    // One-hot decode of issue / writeback destinations; x0 never hits
    always_comb begin
        w_iss_hit = '0;
        w_wb_hit  = '0;
        if (issue_i && issue_wr_i)  w_iss_hit[issue_rd_i] = 1'b1;
        if (wb_valid_i && wb_wr_i)  w_wb_hit[wb_rd_i]     = 1'b1;
        w_iss_hit[0] = 1'b0;
        w_wb_hit[0]  = 1'b0;
    end

    // Per-register next state: issue values win over countdown and long_done
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_rdy_nxt = '0;
        w_lng_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_rdy_nxt[r] = (r_rdy[r] != 2'd0) ? r_rdy[r] - 2'd1 : 2'd0;
            w_lng_nxt[r] = r_lng[r] & ~w_long_clr;
            if (w_iss_hit[r]) begin
                // issue+wb on the same rd: one writer in, one out
                if (!w_wb_hit[r] && r_cnt[r] != 2'd3) w_cnt_nxt[r] = r_cnt[r] + 2'd1;
                w_rdy_nxt[r] = (issue_kind_i == KIND_LOAD) ? LOAD_RDY : 2'd0;
                w_lng_nxt[r] = (issue_kind_i == KIND_LONG);
            end else if (w_wb_hit[r] && r_cnt[r] != 2'd0) begin
                w_cnt_nxt[r] = r_cnt[r] - 2'd1;
                if (r_cnt[r] == 2'd1) begin
                    w_rdy_nxt[r] = 2'd0;
                    w_lng_nxt[r] = 1'b0;
                end
            end
        end
        w_cnt_nxt[0] = 2'd0;
    end

    // Scoreboard registers
    always_ff @(posedge clk_i) begin
        if (!rsn_i || flush_i) begin
            r_cnt <= '0;
            r_rdy <= '0;
            r_lng <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_rdy <= w_rdy_nxt;
            r_lng <= w_lng_nxt;
        end
    end

    assign w_rs1_blk = id_valid_i & id_use_rs1_i & (id_rs1_i != 5'd0) &
                       (r_cnt[id_rs1_i] != 2'd0) &
                       ((r_rdy[id_rs1_i] != 2'd0) | (r_lng[id_rs1_i] & w_busy));
    assign w_rs2_blk = id_valid_i & id_use_rs2_i & (id_rs2_i != 5'd0) &
                       (r_cnt[id_rs2_i] != 2'd0) &
                       ((r_rdy[id_rs2_i] != 2'd0) | (r_lng[id_rs2_i] & w_busy));
    assign w_struct  = id_valid_i & id_long_i & w_busy;

    assign stall_id_o  = rsn_i & (w_rs1_blk | w_rs2_blk | w_struct);
    assign long_busy_o = rsn_i & w_busy;

    // Pending view: any in-flight writer, forced low while in reset
    always_comb begin
        pending_o = '0;
        for (int r = 1; r < NUM_REGS; r++) pending_o[r] = rsn_i & (r_cnt[r] != 2'd0);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed test-plan steps followed
// by constrained-random traffic, all checked against a time-stamp model.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;

    logic        clk = 1'b0;
    logic        rsn, id_valid, id_use_rs1, id_use_rs2, id_long;
    logic [4:0]  id_rs1, id_rs2, issue_rd, wb_rd;
    logic        issue, issue_wr, long_done, wb_valid, wb_wr, flush;
    logic [1:0]  issue_kind;
    logic        stall_id_o, long_busy_o;
    logic [31:0] pending_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: writer count, absolute cycle at which the youngest
    // writer becomes bypassable, youngest-is-long flag, long-unit busy.
    int m_cnt[32];
    int m_ready[32];
    bit m_long[32];
    bit m_busy;
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(LOAD_LAT)) dut (
        .clk_i(clk), .rsn_i(rsn), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_long_i(id_long),
        .issue_i(issue), .issue_wr_i(issue_wr), .issue_rd_i(issue_rd),
        .issue_kind_i(issue_kind), .long_done_i(long_done),
        .wb_valid_i(wb_valid), .wb_wr_i(wb_wr), .wb_rd_i(wb_rd), .flush_i(flush),
        .stall_id_o(stall_id_o), .long_busy_o(long_busy_o), .pending_o(pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_blk(input logic [4:0] rs, input logic use_rs);
        return id_valid && use_rs && rs != 0 && m_cnt[rs] != 0 &&
               (cyc < m_ready[rs] || (m_long[rs] && m_busy));
    endfunction

    function automatic bit m_stall();
        if (!rsn) return 1'b0;
        return m_blk(id_rs1, id_use_rs1) || m_blk(id_rs2, id_use_rs2) ||
               (id_valid && id_long && m_busy);
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = rsn && m_cnt[r] != 0;
        return p;
    endfunction

    task automatic model_edge();
        bit iss, wb, same;
        cyc++;
        if (!rsn || flush) begin
            for (int r = 0; r < 32; r++) begin
                m_cnt[r] = 0; m_ready[r] = 0; m_long[r] = 0;
            end
            m_busy = 0;
            return;
        end
        if (long_done && m_busy) begin
            m_busy = 0;
            for (int r = 0; r < 32; r++) m_long[r] = 0;
        end
        if (issue && issue_kind == 2) m_busy = 1;
        iss  = issue && issue_wr && issue_rd != 0;
        wb   = wb_valid && wb_wr && wb_rd != 0;
        same = iss && wb && issue_rd == wb_rd;
        if (wb && !same) begin
            if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
            if (m_cnt[wb_rd] == 0) begin m_ready[wb_rd] = 0; m_long[wb_rd] = 0; end
        end
        if (iss) begin
            if (!same && m_cnt[issue_rd] < 3) m_cnt[issue_rd]++;
            m_ready[issue_rd] = cyc + ((issue_kind == 1) ? LOAD_LAT : 0);
            m_long[issue_rd]  = (issue_kind == 2);
        end
    endtask

    // Check outputs against the model mid-cycle, then advance one clock
    task automatic tick();
        #1;
        chk("stall", stall_id_o, m_stall());
        chk("busy", long_busy_o, m_busy && rsn);
        chk("pending", pending_o, m_pend());
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_long = 0;
        issue = 0; issue_wr = 0; issue_rd = 0; issue_kind = 0; long_done = 0;
        wb_valid = 0; wb_wr = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [1:0] kind);
        idle(); issue = 1; issue_wr = 1; issue_rd = rd; issue_kind = kind;
    endtask

    task automatic id_read(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic lng);
        idle(); id_valid = 1; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_long = lng;
    endtask

    task automatic do_wb(input logic [4:0] rd);
        idle(); wb_valid = 1; wb_wr = 1; wb_rd = rd;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_ready[r] = 0; m_long[r] = 0; end
        m_busy = 0;
        idle(); rsn = 0;
        @(negedge clk);
        // reset: outputs low even with a would-be stall on the ID inputs
        id_read(5'd1, 5'd2, 1, 1, 1);
        #1 chk("rst_stall", stall_id_o, 0);
        chk("rst_busy", long_busy_o, 0);
        chk("rst_pend", pending_o, 0);
        tick(); tick();
        rsn = 1; idle(); tick();

        // ALU producer -> dependent: no stall; WB clears pending
        do_issue(5'd5, 2'd0); tick();
        id_read(5'd5, 5'd0, 1, 0, 0);
        #1 chk("alu_dep_stall", stall_id_o, 0);
        chk("alu_pend", pending_o[5], 1);
        tick();
        idle(); tick();
        do_wb(5'd5); tick();
        chk("alu_wb_pend", pending_o[5], 0);

        // LOAD -> dependent on rs2: LOAD_LAT stall cycles
        do_issue(5'd7, 2'd1); tick();
        id_read(5'd0, 5'd7, 0, 1, 0);
        #1 chk("ld_use_stall", stall_id_o, 1);
        tick();
        chk("ld_use_release", stall_id_o, 0);
        tick();
        do_issue(5'd7, 2'd1); tick();
        id_read(5'd0, 5'd7, 0, 0, 0);
        #1 chk("ld_nouse_stall", stall_id_o, 0);
        tick();
        do_wb(5'd7); tick();
        do_wb(5'd7); tick();

        // LONG rd=9: data stall until the cycle after long_done
        do_issue(5'd9, 2'd2); tick();
        chk("long_busy", long_busy_o, 1);
        id_read(5'd9, 5'd0, 1, 0, 0);
        tick(); tick();
        long_done = 1;
        #1 chk("long_done_cycle_stall", stall_id_o, 1);
        tick();
        long_done = 0;
        #1 chk("long_after_stall", stall_id_o, 0);
        chk("long_after_busy", long_busy_o, 0);
        tick();
        do_wb(5'd9); tick();

        // Structural stall: ID long op with unrelated operands
        do_issue(5'd10, 2'd2); tick();
        id_read(5'd1, 5'd2, 1, 1, 1);
        #1 chk("struct_stall", stall_id_o, 1);
        tick();
        long_done = 1; tick();
        long_done = 0;
        #1 chk("struct_release", stall_id_o, 0);
        tick();
        do_wb(5'd10); tick();

        // Two writers to x3, then issue+wb same cycle keeps count at 2
        do_issue(5'd3, 2'd0); tick();
        do_issue(5'd3, 2'd0); tick();
        do_issue(5'd3, 2'd0); wb_valid = 1; wb_wr = 1; wb_rd = 5'd3; tick();
        chk("x3_pend_same", pending_o[3], 1);
        do_wb(5'd3); tick();
        chk("x3_pend_one_left", pending_o[3], 1);
        do_wb(5'd3); tick();
        chk("x3_pend_drained", pending_o[3], 0);

        // rd=0 issues of every kind leave no state (LONG still occupies the unit)
        for (int k = 0; k < 4; k++) begin
            do_issue(5'd0, 2'(k)); tick();
        end
        id_read(5'd0, 5'd0, 1, 1, 0);
        #1 chk("x0_stall", stall_id_o, 0);
        chk("x0_pend", pending_o, 0);
        tick();
        idle(); long_done = 1; tick();

        // Flush mid-LBUSY with loads pending, then the same with reset
        for (int pass = 0; pass < 2; pass++) begin
            do_issue(5'd11, 2'd2); tick();
            do_issue(5'd12, 2'd1); tick();
            do_issue(5'd13, 2'd1); tick();
            id_read(5'd13, 5'd11, 1, 1, 1);
            #1 chk("pre_clear_stall", stall_id_o, 1);
            if (pass == 0) flush = 1; else rsn = 0;
            tick();
            flush = 0; rsn = 1;
            #1 chk("clr_pend", pending_o, 0);
            chk("clr_busy", long_busy_o, 0);
            chk("clr_stall", stall_id_o, 0);
            tick();
        end

        // Constrained-random traffic on a small register window
        for (int i = 0; i < 3000; i++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            id_long    = ($urandom_range(0, 3) == 0);
            issue      = 0;
            issue_wr   = 1'($urandom);
            issue_rd   = 5'($urandom_range(0, 7));
            issue_kind = 2'($urandom);
            if (!m_stall()) issue = ($urandom_range(0, 2) != 0);
            long_done  = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            wb_valid   = 1'($urandom);
            wb_wr      = ($urandom_range(0, 3) != 0);
            wb_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 99) == 0);
            rsn        = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
